car_voltage_sampler: RTL and testbench

Sequencer for the LTC2308 SPI ADC that supplies the 12-bit battery-voltage word read by the Nios through the car voltage PIO input port. Periodically starts a conversion, clocks the result out over SPI, drops stale results after a channel change, and holds the latest sample stable on a 12-bit bus that feeds the PIO `in_port` directly. Also flags low battery against a programmable threshold.

---
 rtl/car_voltage_pkg.sv | 39 +++
 rtl/car_voltage_spi_shift.sv | 90 +++++++++
 rtl/car_voltage_sampler.sv | 202 ++++++++++++++++++++
 tb/tb_car_voltage_sampler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/car_voltage_pkg.sv
// car_voltage_pkg
// Shared definitions for the car battery-voltage sampler:
//   - sequencer state encoding
//   - LTC2308 config-word bit positions and a builder for the word
//   - default low-battery threshold in ADC codes
package car_voltage_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONVST = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Bit positions inside the 6-bit config word, sent MSB (S/D) first
   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   localparam logic [11:0] LOW_THRESH_DEF = 12'd2600;

   // Single-ended, unipolar, no sleep; channel bits mapped as O/S = ch[0], S1 = ch[2], S0 = ch[1]
   function automatic logic [5:0] cfg_word(input logic [2:0] ch);
      logic [5:0] w;
      w          = 6'd0;
      w[CFG_SD]  = 1'b1;
      w[CFG_OS]  = ch[0];
      w[CFG_S1]  = ch[2];
      w[CFG_S0]  = ch[1];
      w[CFG_UNI] = 1'b1;
      w[CFG_SLP] = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/car_voltage_spi_shift.sv
// car_voltage_spi_shift
// SCK generator plus 12-bit SPI shifter for one LTC2308 frame.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle pulse that begins a 12-bit frame
//   tx_cfg[5:0] : config word, sent MSB first on bits 0-5, zeros after
//   sdo         : serial data from the ADC
//   sck, sdi    : registered SPI clock (idle low) and data to the ADC
//   done        : high in the last cycle of the frame
//   rx[11:0]    : received word, MSB first
module car_voltage_spi_shift
   import car_voltage_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  tx_cfg,
   input  logic        sdo,
   output logic        sck,
   output logic        sdi,
   output logic        done,
   output logic [11:0] rx
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic          active_r;
   logic          half_r;     // 0: SCK low half, 1: SCK high half
   logic [DW-1:0] div_r;
   logic [3:0]    bit_r;
   logic [5:0]    cfg_r;
   logic          sck_r;
   logic          sdi_r;
   logic [11:0]   rx_r;
   logic          edge_s;

   // Last clk cycle of the current SCK half period
   assign edge_s = active_r && (div_r == DIV_LAST);
   assign done   = edge_s && half_r && (bit_r == 4'd11);
   assign sck    = sck_r;
   assign sdi    = sdi_r;
   assign rx     = rx_r;

   // Half-period sequencing, SDI launch on SCK fall, SDO capture on SCK rise
   always_ff @(posedge clk) begin
      if (reset) begin
         active_r <= 1'b0;
         half_r   <= 1'b0;
         div_r    <= '0;
         bit_r    <= 4'd0;
         cfg_r    <= 6'd0;
         sck_r    <= 1'b0;
         sdi_r    <= 1'b0;
         rx_r     <= 12'd0;
      end else if (start) begin
         active_r <= 1'b1;
         half_r   <= 1'b0;
         div_r    <= '0;
         bit_r    <= 4'd0;
         cfg_r    <= tx_cfg;
         sck_r    <= 1'b0;
         sdi_r    <= tx_cfg[5];
      end else if (edge_s) begin
         div_r <= '0;
         if (!half_r) begin
            half_r <= 1'b1;
            sck_r  <= 1'b1;
            rx_r   <= {rx_r[10:0], sdo};
         end else if (bit_r == 4'd11) begin
            active_r <= 1'b0;
            half_r   <= 1'b0;
            sck_r    <= 1'b0;
            sdi_r    <= 1'b0;
         end else begin
            half_r <= 1'b0;
            sck_r  <= 1'b0;
            bit_r  <= bit_r + 4'd1;
            // Config word drains out of the top; zeros follow after bit 5
            cfg_r  <= {cfg_r[4:0], 1'b0};
            sdi_r  <= cfg_r[4];
         end
      end else if (active_r) begin
         div_r <= div_r + 1'b1;
      end
   end

endmodule

// File: rtl/car_voltage_sampler.sv
// car_voltage_sampler
// Periodic LTC2308 sequencer producing the 12-bit battery-voltage word for the PIO.
// Optional feature macro: CAR_VOLT_AVG_EN (4-sample running average of accepted samples).
// Ports:
//   clk, reset          : 50 MHz clock, synchronous active-high reset
//   enable              : run periodic sampling; low lets the current frame finish then idles
//   channel[2:0]        : ADC channel, latched when a conversion starts
//   adc_convst          : CONVST to the ADC
//   adc_sck/adc_sdi     : SPI clock and config data to the ADC
//   adc_sdo             : SPI data from the ADC
//   sample_data[11:0]   : latest accepted sample, stable between updates
//   sample_valid        : one-cycle pulse on each sample_data update
//   low_batt            : sample_data below LOW_THRESH
//   busy                : sequencer not idle
module car_voltage_sampler
   import car_voltage_pkg::*;
#(
   parameter int          CLK_DIV     = 2,
   parameter int          CONV_CYCLES = 80,
   parameter int          PERIOD      = 50000,
   parameter logic [11:0] LOW_THRESH  = LOW_THRESH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [2:0]  channel,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo,
   output logic [11:0] sample_data,
   output logic        sample_valid,
   output logic        low_batt,
   output logic        busy
);

   localparam int PW = $clog2(PERIOD);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
   localparam int CW = $clog2(CONV_CYCLES + 2);
   localparam logic [CW-1:0] WAIT_LAST = CW'(CONV_CYCLES - 1);

   state_t        state_r, state_nxt;
   logic [CW-1:0] cnt_r, cnt_nxt;
   logic [PW-1:0] timer_r;
   logic          tick_r;
   logic [2:0]    ch_q_r;
   logic [2:0]    prev_ch_r;
   logic          discard_r;
   logic          convst_r;
   logic          busy_r;
   logic [11:0]   sample_data_r;
   logic          sample_valid_r;
   logic          low_batt_r;
   logic          start_s;
   logic          spi_done_s;
   logic [11:0]   rx_s;
   logic          ch_match_s;
   logic          accept_s;
   logic          out_upd_s;
   logic [11:0]   out_val_s;

   car_voltage_spi_shift #(.CLK_DIV(CLK_DIV)) u_spi (
      .clk    (clk),
      .reset  (reset),
      .start  (start_s),
      .tx_cfg (cfg_word(ch_q_r)),
      .sdo    (adc_sdo),
      .sck    (adc_sck),
      .sdi    (adc_sdi),
      .done   (spi_done_s),
      .rx     (rx_s)
   );

   // The result read in this frame belongs to the previous frame's config word
   assign ch_match_s = (ch_q_r == prev_ch_r);
   assign accept_s   = (state_r == ST_DONE) && !discard_r && ch_match_s;

`ifdef CAR_VOLT_AVG_EN
   logic [11:0] ring_r [4];
   logic [1:0]  wr_ptr_r;
   logic [2:0]  fill_r;
   logic [13:0] sum_r;
   logic [13:0] sum_nxt_s;

   // Unfilled slots hold zero, so the subtraction is harmless while filling
   assign sum_nxt_s = sum_r + {2'b00, rx_s} - {2'b00, ring_r[wr_ptr_r]};
   assign out_upd_s = accept_s && (fill_r >= 3'd3);
   assign out_val_s = sum_nxt_s[13:2];

   // Ring buffer and running sum; a channel change restarts the average
   always_ff @(posedge clk) begin
      if (reset || ((state_r == ST_DONE) && !ch_match_s)) begin
         for (int i = 0; i < 4; i++) ring_r[i] <= 12'd0;
         wr_ptr_r <= 2'd0;
         fill_r   <= 3'd0;
         sum_r    <= 14'd0;
      end else if (accept_s) begin
         ring_r[wr_ptr_r] <= rx_s;
         wr_ptr_r         <= wr_ptr_r + 2'd1;
         sum_r            <= sum_nxt_s;
         fill_r           <= (fill_r == 3'd4) ? 3'd4 : fill_r + 3'd1;
      end
   end
`else
   assign out_upd_s = accept_s;
   assign out_val_s = rx_s;
`endif

   // Next-state logic for the conversion sequencer
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      start_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (tick_r && enable) state_nxt = ST_CONVST;
            else                  state_nxt = ST_IDLE;
         end
         ST_CONVST: begin
            if (cnt_r == CW'(1)) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_r + 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_r == WAIT_LAST) begin
               state_nxt = ST_SHIFT;
               cnt_nxt   = '0;
               start_s   = 1'b1;
            end else begin
               cnt_nxt = cnt_r + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (spi_done_s) state_nxt = ST_DONE;
            else            state_nxt = ST_SHIFT;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, counters, period timer and channel bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         timer_r   <= '0;
         tick_r    <= 1'b0;
         ch_q_r    <= 3'd0;
         prev_ch_r <= 3'd0;
         discard_r <= 1'b1;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         if (!enable) begin
            timer_r <= '0;
            tick_r  <= 1'b0;
         end else if (timer_r == PERIOD_LAST) begin
            timer_r <= '0;
            tick_r  <= 1'b1;
         end else begin
            timer_r <= timer_r + 1'b1;
            tick_r  <= 1'b0;
         end
         if ((state_r == ST_IDLE) && (state_nxt == ST_CONVST)) ch_q_r <= channel;
         if (state_r == ST_DONE) begin
            prev_ch_r <= ch_q_r;
            discard_r <= 1'b0;
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         convst_r       <= 1'b0;
         busy_r         <= 1'b0;
         sample_data_r  <= 12'd0;
         sample_valid_r <= 1'b0;
         low_batt_r     <= 1'b0;
      end else begin
         convst_r       <= (state_nxt == ST_CONVST);
         busy_r         <= (state_nxt != ST_IDLE);
         sample_valid_r <= out_upd_s;
         if (out_upd_s) begin
            sample_data_r <= out_val_s;
            low_batt_r    <= (out_val_s < LOW_THRESH);
         end
      end
   end

   assign adc_convst   = convst_r;
   assign busy         = busy_r;
   assign sample_data  = sample_data_r;
   assign sample_valid = sample_valid_r;
   assign low_batt     = low_batt_r;

endmodule

// File: tb/tb_car_voltage_sampler.sv
// tb_car_voltage_sampler
// Directed bench for car_voltage_sampler with a simple LTC2308 model.
// PERIOD is shortened so several frames fit in a short run; other parameters are defaults.
module tb_car_voltage_sampler;

   localparam int PERIOD_TB = 400;
   // CONVST rises one cycle after the tick, so valid follows CONVST by the tick latency minus one
   localparam int LAT_EXP = 1 + 2 + 80 + 24 * 2 + 1 - 1;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [2:0]  channel;
   logic        adc_convst;
   logic        adc_sck;
   logic        adc_sdi;
   logic        adc_sdo;
   logic [11:0] sample_data;
   logic        sample_valid;
   logic        low_batt;
   logic        busy;

   int          total;
   int          bad;
   int          cyc;
   int          t0;
   int          conv_w;
   int          nrise;
   logic [11:0] adc_word;
   logic [11:0] sh;
   logic [11:0] sdi_cap;

   car_voltage_sampler #(
      .CLK_DIV     (2),
      .CONV_CYCLES (80),
      .PERIOD      (PERIOD_TB),
      .LOW_THRESH  (12'd2600)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .channel      (channel),
      .adc_convst   (adc_convst),
      .adc_sck      (adc_sck),
      .adc_sdi      (adc_sdi),
      .adc_sdo      (adc_sdo),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .low_batt     (low_batt),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: word loaded at CONVST, MSB first, next bit after each SCK fall
   always @(posedge adc_convst or negedge adc_sck) begin
      if (adc_convst) sh = adc_word;
      else            sh = {sh[10:0], 1'b0};
      adc_sdo = sh[11];
   end

   // Capture of SDI as the ADC sees it on SCK rise
   always @(posedge adc_convst or posedge adc_sck) begin
      if (adc_convst) begin
         sdi_cap = 12'd0;
         nrise   = 0;
      end else begin
         sdi_cap = {sdi_cap[10:0], adc_sdi};
         nrise   = nrise + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_convst();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2 * PERIOD_TB + 20; i++) begin
         @(negedge clk);
         if (adc_convst) begin
            ok     = 1'b1;
            t0     = cyc;
            conv_w = 1;
            break;
         end
      end
      check("convst_start", {31'd0, ok}, 32'd1);
   endtask

   task automatic finish_frame(output bit seen, output int lat, output logic pre_low);
      seen    = 1'b0;
      lat     = 0;
      pre_low = low_batt;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (adc_convst) conv_w++;
         if (sample_valid) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end else if (!seen) begin
            pre_low = low_batt;
         end
         if (!busy) break;
      end
      check("frame_end", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_frame(output bit seen, output int lat, output logic pre_low);
      wait_convst();
      finish_frame(seen, lat, pre_low);
   endtask

   initial begin
      bit   seen;
      int   lat;
      logic pre_low;
      int   any;

      total    = 0;
      bad      = 0;
      cyc      = 0;
      reset    = 1'b1;
      enable   = 1'b0;
      channel  = 3'd0;
      adc_word = 12'hABC;
      adc_sdo  = 1'b0;
      repeat (4) @(negedge clk);

      check("rst_convst", {31'd0, adc_convst}, 32'd0);
      check("rst_sck", {31'd0, adc_sck}, 32'd0);
      check("rst_sdi", {31'd0, adc_sdi}, 32'd0);
      check("rst_data", {20'd0, sample_data}, 32'd0);
      check("rst_valid", {31'd0, sample_valid}, 32'd0);
      check("rst_low", {31'd0, low_batt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);

      reset  = 1'b0;
      enable = 1'b1;

`ifdef CAR_VOLT_AVG_EN
      adc_word = 12'd100;
      run_frame(seen, lat, pre_low);
      check("avg_first_discard", {31'd0, seen}, 32'd0);
      run_frame(seen, lat, pre_low);
      check("avg_fill1", {31'd0, seen}, 32'd0);
      adc_word = 12'd200;
      run_frame(seen, lat, pre_low);
      check("avg_fill2", {31'd0, seen}, 32'd0);
      adc_word = 12'd300;
      run_frame(seen, lat, pre_low);
      check("avg_fill3", {31'd0, seen}, 32'd0);
      adc_word = 12'd400;
      run_frame(seen, lat, pre_low);
      check("avg4_valid", {31'd0, seen}, 32'd1);
      check("avg4_data", {20'd0, sample_data}, 32'd250);
      adc_word = 12'd500;
      run_frame(seen, lat, pre_low);
      check("avg5_valid", {31'd0, seen}, 32'd1);
      check("avg5_data", {20'd0, sample_data}, 32'd350);
      check("avg5_low", {31'd0, low_batt}, 32'd1);
`else
      // First frame after reset is discarded; config word for channel 0
      run_frame(seen, lat, pre_low);
      check("first_discard", {31'd0, seen}, 32'd0);
      check("first_data", {20'd0, sample_data}, 32'd0);
      check("sck_count", nrise, 32'd12);
      check("cfg_ch0", {26'd0, sdi_cap[11:6]}, 32'b100010);

      run_frame(seen, lat, pre_low);
      check("abc_valid", {31'd0, seen}, 32'd1);
      check("abc_latency", lat, LAT_EXP);
      check("abc_data", {20'd0, sample_data}, 32'hABC);
      check("abc_low", {31'd0, low_batt}, 32'd0);
      check("convst_width", conv_w, 32'd2);

      adc_word = 12'd2599;
      run_frame(seen, lat, pre_low);
      check("v2599_valid", {31'd0, seen}, 32'd1);
      check("v2599_data", {20'd0, sample_data}, 32'd2599);
      check("v2599_pre_low", {31'd0, pre_low}, 32'd0);
      check("v2599_low", {31'd0, low_batt}, 32'd1);

      adc_word = 12'd2600;
      run_frame(seen, lat, pre_low);
      check("v2600_data", {20'd0, sample_data}, 32'd2600);
      check("v2600_pre_low", {31'd0, pre_low}, 32'd1);
      check("v2600_low", {31'd0, low_batt}, 32'd0);

      // Channel change between ticks: next frame dropped, following accepted
      channel  = 3'd3;
      adc_word = 12'h123;
      run_frame(seen, lat, pre_low);
      check("chg_discard", {31'd0, seen}, 32'd0);
      check("chg_data_hold", {20'd0, sample_data}, 32'd2600);
      check("cfg_ch3", {26'd0, sdi_cap[11:6]}, 32'b110110);
      check("cfg_tail_zero", {26'd0, sdi_cap[5:0]}, 32'd0);
      run_frame(seen, lat, pre_low);
      check("chg_accept", {31'd0, seen}, 32'd1);
      check("chg_data", {20'd0, sample_data}, 32'h123);

      // Reset during SHIFT bit 5
      adc_word = 12'h321;
      wait_convst();
      for (int i = 0; i < 300; i++) begin
         if (nrise == 6) break;
         @(negedge clk);
      end
      check("reach_bit5", nrise, 32'd6);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_sck", {31'd0, adc_sck}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_data", {20'd0, sample_data}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_frame(seen, lat, pre_low);
      check("post_rst_discard", {31'd0, seen}, 32'd0);
      run_frame(seen, lat, pre_low);
      check("post_rst_accept", {31'd0, seen}, 32'd1);
      check("post_rst_data", {20'd0, sample_data}, 32'h321);

      // Enable dropped during WAIT: frame completes, then no more CONVST
      adc_word = 12'h456;
      wait_convst();
      repeat (20) @(negedge clk);
      enable = 1'b0;
      finish_frame(seen, lat, pre_low);
      check("en_drop_valid", {31'd0, seen}, 32'd1);
      check("en_drop_data", {20'd0, sample_data}, 32'h456);
      any = 0;
      for (int i = 0; i < 3 * PERIOD_TB; i++) begin
         @(negedge clk);
         if (adc_convst || busy) any++;
      end
      check("en_drop_idle", any, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
